// File: rtl/parity_pkg.sv
// Shared definitions for the packet parity source and tester: response codes,
// source FSM encoding and the LFSR feedback taps.
package parity_pkg;

    localparam logic [7:0] RESP_ODD      = 8'hFF;
    localparam logic [7:0] RESP_EVEN     = 8'hAB;
    // Taps d7,d5,d4,d3 for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/parity_lfsr8.sv
// 8-bit Fibonacci LFSR (shift left, feedback into bit 0) that advances only
// when enabled; an all-zero seed is replaced so the register never locks up.
module parity_lfsr8
    import parity_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       in_clock,
    input  logic       in_reset_n,
    input  logic       in_advance,
    output logic [7:0] out_value
);

    localparam logic [7:0] LOAD_VALUE = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAP_MASK)};
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            lfsr_q <= LOAD_VALUE;
        end else if (in_advance) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out_value = lfsr_q;

endmodule

// File: rtl/parity_packet_source.sv
// Closed-loop stimulus source: emits LFSR byte packets, tracks their XOR
// parity and scores the first beat of each response against the expected code.
module parity_packet_source
    import parity_pkg::*;
#(
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        in_clock,
    input  logic        in_reset_n,
    input  logic        in_start,
    input  logic [7:0]  in_pkt_len,
    // Both streams: a beat transfers on a rising edge where tvalid & tready;
    // a raised tvalid holds tdata/tlast stable until that transfer.
    output logic        axis_m_tvalid,
    output logic [7:0]  axis_m_tdata,
    input  logic        axis_m_tready,
    output logic        axis_m_tlast,
    input  logic        axis_s_tvalid,
    input  logic [7:0]  axis_s_tdata,
    output logic        axis_s_tready,
    input  logic        axis_s_tlast,
    output logic        out_busy,
    output logic        out_done,
    output logic [15:0] out_pass_count,
    output logic [15:0] out_fail_count,
    output logic [2:0]  out_dbg_state
);

    localparam logic [15:0] TMO_LAST = (RESP_TIMEOUT <= 1) ? 16'd0 : 16'(RESP_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST = (GAP_CYCLES <= 1)   ? 8'd0  : 8'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic        parity_q;
    logic [15:0] tmo_q;
    logic [7:0]  gap_q;
    logic        m_tvalid_q;
    logic        m_tlast_q;
    logic        s_tready_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] pass_q;
    logic [15:0] fail_q;

    logic        m_hs;
    logic        s_hs;
    logic [7:0]  lfsr_value;
    logic        parity_d;
    logic [7:0]  cnt_d;
    logic [7:0]  len_d;
    logic [7:0]  expect_code;

    assign m_hs = m_tvalid_q & axis_m_tready;
    assign s_hs = axis_s_tvalid & s_tready_q;

    parity_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .in_clock   (in_clock),
        .in_reset_n (in_reset_n),
        .in_advance (m_hs),
        .out_value  (lfsr_value)
    );

    always_comb begin
        parity_d    = parity_q ^ (^lfsr_value);
        cnt_d       = cnt_q + 8'd1;
        len_d       = (in_pkt_len == 8'd0) ? 8'd1 : in_pkt_len;
        expect_code = parity_q ? RESP_ODD : RESP_EVEN;
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'd0;
            cnt_q      <= 8'd0;
            parity_q   <= 1'b0;
            tmo_q      <= 16'd0;
            gap_q      <= 8'd0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            s_tready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 16'd0;
            fail_q     <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_start) begin
                        len_q      <= len_d;
                        cnt_q      <= 8'd0;
                        parity_q   <= 1'b0;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= (len_d == 8'd1);
                        busy_q     <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_hs) begin
                        parity_q <= parity_d;
                        cnt_q    <= cnt_d;
                        if (m_tlast_q) begin
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            tmo_q      <= 16'd0;
                            s_tready_q <= 1'b1;
                            state_q    <= ST_WAIT_RESP;
                        end else begin
                            // tlast is registered, so look one byte ahead
                            m_tlast_q <= (cnt_d == len_q - 8'd1);
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (s_hs) begin
                        if (axis_s_tdata == expect_code) begin
                            pass_q <= sat_inc16(pass_q);
                        end else begin
                            fail_q <= sat_inc16(fail_q);
                        end
                        if (axis_s_tlast) begin
                            s_tready_q <= 1'b0;
                            gap_q      <= 8'd0;
                            state_q    <= ST_GAP;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        fail_q     <= sat_inc16(fail_q);
                        s_tready_q <= 1'b0;
                        gap_q      <= 8'd0;
                        state_q    <= ST_GAP;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (s_hs && axis_s_tlast) begin
                        s_tready_q <= 1'b0;
                        gap_q      <= 8'd0;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: begin
                    m_tvalid_q <= 1'b0;
                    m_tlast_q  <= 1'b0;
                    s_tready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign axis_m_tvalid  = m_tvalid_q;
    assign axis_m_tdata   = m_tvalid_q ? lfsr_value : 8'h00;
    assign axis_m_tlast   = m_tlast_q;
    assign axis_s_tready  = s_tready_q;
    assign out_busy       = busy_q;
    assign out_done       = done_q;
    assign out_pass_count = pass_q;
    assign out_fail_count = fail_q;
    assign out_dbg_state  = state_q;

endmodule

// File: tb/tb_parity_packet_source.sv
// Directed bench for parity_packet_source: packet bytes, parity scoring,
// backpressure, response timeout, draining, start handling and async reset.
`timescale 1ns/1ps
module tb_parity_packet_source;

    logic        in_clock = 1'b0;
    logic        in_reset_n = 1'b0;
    logic        in_start = 1'b0;
    logic [7:0]  in_pkt_len = 8'd0;
    logic        axis_m_tvalid;
    logic [7:0]  axis_m_tdata;
    logic        axis_m_tready = 1'b0;
    logic        axis_m_tlast;
    logic        axis_s_tvalid = 1'b0;
    logic [7:0]  axis_s_tdata = 8'd0;
    logic        axis_s_tready;
    logic        axis_s_tlast = 1'b0;
    logic        out_busy;
    logic        out_done;
    logic [15:0] out_pass_count;
    logic [15:0] out_fail_count;
    logic [2:0]  out_dbg_state;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] exp_q[$];

    parity_packet_source dut (
        .in_clock       (in_clock),
        .in_reset_n     (in_reset_n),
        .in_start       (in_start),
        .in_pkt_len     (in_pkt_len),
        .axis_m_tvalid  (axis_m_tvalid),
        .axis_m_tdata   (axis_m_tdata),
        .axis_m_tready  (axis_m_tready),
        .axis_m_tlast   (axis_m_tlast),
        .axis_s_tvalid  (axis_s_tvalid),
        .axis_s_tdata   (axis_s_tdata),
        .axis_s_tready  (axis_s_tready),
        .axis_s_tlast   (axis_s_tlast),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_pass_count (out_pass_count),
        .out_fail_count (out_fail_count),
        .out_dbg_state  (out_dbg_state)
    );

    // Clock / reset
    always #5 in_clock = ~in_clock;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        in_reset_n    = 1'b0;
        in_start      = 1'b0;
        in_pkt_len    = 8'd0;
        axis_m_tready = 1'b0;
        axis_s_tvalid = 1'b0;
        axis_s_tdata  = 8'd0;
        axis_s_tlast  = 1'b0;
        repeat (3) @(negedge in_clock);
        in_reset_n = 1'b1;
        @(negedge in_clock);
    endtask

    // Driver tasks; all called at a falling edge, return at a falling edge
    task automatic start_pkt(input logic [7:0] len, input bit hold);
        in_start   = 1'b1;
        in_pkt_len = len;
        @(negedge in_clock);
        if (!hold) in_start = 1'b0;
    endtask

    task automatic collect_pkt(input int max_cycles);
        got_q.delete();
        got_last_q.delete();
        for (int c = 0; c < max_cycles; c++) begin
            axis_m_tready = 1'b1;
            if (axis_m_tvalid) begin
                got_q.push_back(axis_m_tdata);
                got_last_q.push_back(axis_m_tlast);
            end
            @(negedge in_clock);
            if (got_last_q.size() > 0 && got_last_q[$] == 1'b1) break;
        end
        axis_m_tready = 1'b0;
    endtask

    task automatic send_resp(input logic [7:0] data, input logic last, output bit accepted);
        axis_s_tvalid = 1'b1;
        axis_s_tdata  = data;
        axis_s_tlast  = last;
        accepted      = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (axis_s_tready) accepted = 1'b1;
            @(negedge in_clock);
            if (accepted) break;
        end
        axis_s_tvalid = 1'b0;
        axis_s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            if (out_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge in_clock);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (axis_m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %0h expected 0", axis_m_tvalid); end
        checks++;
        if (axis_m_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata: got %0h expected 0", axis_m_tdata); end
        checks++;
        if (axis_m_tlast !== 1'b0 || axis_s_tready !== 1'b0) begin failures++; $display("FAIL reset_tlast_tready: got %0h/%0h expected 0/0", axis_m_tlast, axis_s_tready); end
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %0h/%0h expected 0/0", out_busy, out_done); end
        checks++;
        if (out_pass_count !== 16'd0 || out_fail_count !== 16'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", out_pass_count, out_fail_count); end
        checks++;
        if (out_dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", out_dbg_state); end
    endtask

    task automatic test_len1();
        bit acc;
        bit seen;
        apply_reset();
        start_pkt(8'd1, 1'b0);
        collect_pkt(20);
        checks++;
        if (got_q.size() != 1) begin failures++; $display("FAIL len1_count: got %0d expected 1", got_q.size()); end
        checks++;
        if (got_q[0] !== 8'hA5 || got_last_q[0] !== 1'b1) begin failures++; $display("FAIL len1_byte: got %0h last %0h expected a5 last 1", got_q[0], got_last_q[0]); end
        checks++;
        if (axis_s_tready !== 1'b1 || out_busy !== 1'b1) begin failures++; $display("FAIL len1_wait: got tready %0h busy %0h expected 1/1", axis_s_tready, out_busy); end
        send_resp(8'hAB, 1'b1, acc);
        wait_done(10, seen);
        checks++;
        if (!acc || !seen) begin failures++; $display("FAIL len1_resp_done: got acc %0d done %0d expected 1/1", acc, seen); end
        checks++;
        if (out_pass_count !== 16'd1 || out_fail_count !== 16'd0) begin failures++; $display("FAIL len1_counts: got %0d/%0d expected 1/0", out_pass_count, out_fail_count); end
        checks++;
        if (out_busy !== 1'b0) begin failures++; $display("FAIL len1_idle: got busy %0h expected 0", out_busy); end
    endtask

    task automatic test_len2_odd();
        bit acc;
        bit seen;
        apply_reset();
        start_pkt(8'd2, 1'b0);
        collect_pkt(20);
        exp_q = '{8'hA5, 8'h4A};
        checks++;
        if (got_q.size() != 2) begin failures++; $display("FAIL len2_count: got %0d expected 2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 1)) begin
                failures++;
                $display("FAIL len2_byte%0d: got %0h last %0h expected %0h last %0d", i, got_q[i], got_last_q[i], exp_q[i], (i == 1));
            end
        end
        send_resp(8'hFF, 1'b1, acc);
        wait_done(10, seen);
        checks++;
        if (out_pass_count !== 16'd1 || out_fail_count !== 16'd0 || !seen) begin failures++; $display("FAIL len2_pass: got %0d/%0d done %0d expected 1/0 done 1", out_pass_count, out_fail_count, seen); end

        apply_reset();
        start_pkt(8'd2, 1'b0);
        collect_pkt(20);
        send_resp(8'hAB, 1'b1, acc);
        wait_done(10, seen);
        checks++;
        if (out_pass_count !== 16'd0 || out_fail_count !== 16'd1 || !seen) begin failures++; $display("FAIL len2_mismatch: got %0d/%0d done %0d expected 0/1 done 1", out_pass_count, out_fail_count, seen); end
    endtask

    task automatic test_backpressure();
        bit         acc;
        bit         seen;
        bit         stalled;
        logic [7:0] hold_d;
        logic       hold_l;
        apply_reset();
        start_pkt(8'd4, 1'b0);
        got_q.delete();
        got_last_q.delete();
        stalled = 1'b0;
        hold_d  = 8'h00;
        hold_l  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (stalled) begin
                checks++;
                if (axis_m_tvalid !== 1'b1 || axis_m_tdata !== hold_d || axis_m_tlast !== hold_l) begin
                    failures++;
                    $display("FAIL bp_hold: got v%0h d%0h l%0h expected v1 d%0h l%0h", axis_m_tvalid, axis_m_tdata, axis_m_tlast, hold_d, hold_l);
                end
            end
            axis_m_tready = (c % 2 == 1);
            stalled = axis_m_tvalid && !axis_m_tready;
            hold_d  = axis_m_tdata;
            hold_l  = axis_m_tlast;
            if (axis_m_tvalid && axis_m_tready) begin
                got_q.push_back(axis_m_tdata);
                got_last_q.push_back(axis_m_tlast);
            end
            @(negedge in_clock);
            if (got_last_q.size() > 0 && got_last_q[$] == 1'b1) break;
        end
        axis_m_tready = 1'b0;
        exp_q = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
        checks++;
        if (got_q.size() != 4) begin failures++; $display("FAIL bp_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 3)) begin
                failures++;
                $display("FAIL bp_byte%0d: got %0h last %0h expected %0h last %0d", i, got_q[i], got_last_q[i], exp_q[i], (i == 3));
            end
        end
        checks++;
        if (axis_m_tvalid !== 1'b0) begin failures++; $display("FAIL bp_tvalid_after: got %0h expected 0", axis_m_tvalid); end
        send_resp(8'hAB, 1'b1, acc);
        wait_done(10, seen);
        checks++;
        if (out_pass_count !== 16'd1 || out_fail_count !== 16'd0) begin failures++; $display("FAIL bp_counts: got %0d/%0d expected 1/0", out_pass_count, out_fail_count); end
    endtask

    task automatic test_timeout();
        int n;
        int gap_n;
        apply_reset();
        start_pkt(8'd1, 1'b0);
        collect_pkt(20);
        n = 0;
        while (axis_s_tready && n < 200) begin
            n++;
            @(negedge in_clock);
        end
        checks++;
        if (n != 64) begin failures++; $display("FAIL tmo_cycles: got %0d expected 64", n); end
        gap_n = 0;
        while (out_busy && gap_n < 10) begin
            gap_n++;
            @(negedge in_clock);
        end
        checks++;
        if (gap_n != 2 || out_done !== 1'b1) begin failures++; $display("FAIL tmo_gap: got %0d cycles done %0h expected 2 cycles done 1", gap_n, out_done); end
        checks++;
        if (out_fail_count !== 16'd1 || out_pass_count !== 16'd0) begin failures++; $display("FAIL tmo_counts: got %0d/%0d expected 0/1", out_pass_count, out_fail_count); end
    endtask

    task automatic test_multi_beat();
        bit acc0;
        bit acc1;
        bit acc2;
        bit seen;
        apply_reset();
        start_pkt(8'd1, 1'b0);
        collect_pkt(20);
        send_resp(8'hAB, 1'b0, acc0);
        checks++;
        if (out_dbg_state !== 3'd3) begin failures++; $display("FAIL mb_drain_state: got %0d expected 3", out_dbg_state); end
        send_resp(8'h11, 1'b0, acc1);
        send_resp(8'h22, 1'b1, acc2);
        checks++;
        if ({acc0, acc1, acc2} !== 3'b111) begin failures++; $display("FAIL mb_accept: got %b expected 111", {acc0, acc1, acc2}); end
        checks++;
        if (axis_s_tready !== 1'b0) begin failures++; $display("FAIL mb_tready_gap: got %0h expected 0", axis_s_tready); end
        wait_done(10, seen);
        checks++;
        if (!seen || out_pass_count !== 16'd1 || out_fail_count !== 16'd0 || out_dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL mb_result: got done %0d %0d/%0d state %0d expected done 1 1/0 state 0", seen, out_pass_count, out_fail_count, out_dbg_state);
        end
    endtask

    task automatic test_held_start_and_len0();
        bit acc;
        bit seen;
        int extra;
        apply_reset();
        start_pkt(8'd3, 1'b1);
        collect_pkt(30);
        exp_q = '{8'hA5, 8'h4A, 8'h95};
        checks++;
        if (got_q.size() != 3) begin failures++; $display("FAIL hold_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 2)) begin
                failures++;
                $display("FAIL hold_byte%0d: got %0h last %0h expected %0h last %0d", i, got_q[i], got_last_q[i], exp_q[i], (i == 2));
            end
        end
        send_resp(8'hFF, 1'b1, acc);
        in_start = 1'b0;
        wait_done(10, seen);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge in_clock);
            if (axis_m_tvalid) extra++;
        end
        checks++;
        if (extra != 0 || out_pass_count !== 16'd1) begin failures++; $display("FAIL hold_single: got extra %0d pass %0d expected 0/1", extra, out_pass_count); end

        start_pkt(8'd0, 1'b0);
        collect_pkt(20);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h2A || got_last_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL len0_byte: got n%0d %0h last %0h expected n1 2a last 1", got_q.size(), got_q[0], got_last_q[0]);
        end
        send_resp(8'hFF, 1'b1, acc);
        wait_done(10, seen);
        checks++;
        if (out_pass_count !== 16'd2 || out_fail_count !== 16'd0) begin failures++; $display("FAIL len0_counts: got %0d/%0d expected 2/0", out_pass_count, out_fail_count); end
    endtask

    task automatic test_reset_mid_send();
        axis_m_tready = 1'b0;
        start_pkt(8'd5, 1'b0);
        checks++;
        if (axis_m_tvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_tvalid: got %0h expected 1", axis_m_tvalid); end
        #2;
        in_reset_n = 1'b0;
        #1;
        checks++;
        if (axis_m_tvalid !== 1'b0 || axis_m_tdata !== 8'h00 || out_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_outputs: got v%0h d%0h busy%0h expected 0/0/0", axis_m_tvalid, axis_m_tdata, out_busy);
        end
        checks++;
        if (out_pass_count !== 16'd0 || out_fail_count !== 16'd0) begin failures++; $display("FAIL rst_async_counts: got %0d/%0d expected 0/0", out_pass_count, out_fail_count); end
        @(negedge in_clock);
        in_reset_n = 1'b1;
        @(negedge in_clock);
        checks++;
        if (axis_m_tvalid !== 1'b0 || out_dbg_state !== 3'd0) begin failures++; $display("FAIL rst_after: got v%0h state %0d expected 0/0", axis_m_tvalid, out_dbg_state); end
    endtask

    initial begin
        test_reset();
        test_len1();
        test_len2_odd();
        test_backpressure();
        test_timeout();
        test_multi_beat();
        test_held_start_and_len0();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_packet_source.md
Name: parity_packet_source

Overview:
- Upstream stimulus stage for the packet parity tester.
- Generates AXI-Stream byte packets of programmable length from an 8-bit LFSR, with tlast on the final byte.
- Computes each packet's running XOR parity and consumes the tester's response stream.
- Checks the response's first beat against the expected code and keeps pass/fail counters. This gives the parity path closed-loop self-test.

Parameters:
- LFSR_SEED, 8'hA5, LFSR load value at reset; 8'h00 is replaced by 8'h01.
- GAP_CYCLES, 2, idle cycles after each packet's response before out_done and return to IDLE; 0 is legal.
- RESP_TIMEOUT, 64, maximum cycles in WAIT_RESP without a response beat before declaring failure.

Ports:
- in_clock  in  1  clock, all logic on rising edge
- in_reset_n  in  1  asynchronous active-low reset
- in_start  in  1  start pulse; sampled only in IDLE
- in_pkt_len  in  8  packet length in bytes, latched at start; 0 treated as 1
- axis_m_tvalid  out  1  packet byte valid, to tester slave
- axis_m_tdata  out  8  packet byte
- axis_m_tready  in  1  tester ready
- axis_m_tlast  out  1  final byte of packet
- axis_s_tvalid  in  1  response beat valid, from tester master
- axis_s_tdata  in  8  response byte
- axis_s_tready  out  1  response accept
- axis_s_tlast  in  1  final response beat
- out_busy  out  1  high in any state other than IDLE
- out_done  out  1  one-cycle pulse at GAP→IDLE
- out_pass_count  out  16  responses matching expectation, saturating
- out_fail_count  out  16  mismatches plus timeouts, saturating

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs 0; state IDLE.
  - LFSR loaded with LFSR_SEED; parity 0; counters 0.
- States: IDLE, SEND, WAIT_RESP, DRAIN, GAP.
- IDLE:
  - in_start=1 latches len = max(in_pkt_len, 1), clears the byte counter and parity, and moves to SEND next cycle.
  - in_start is ignored in every other state.
- SEND:
  - axis_m_tvalid=1, axis_m_tdata=LFSR, axis_m_tlast=1 when the byte counter equals len-1.
  - On handshake (tvalid & tready): parity ^= ^tdata, LFSR advances, counter++.
  - tdata and tlast hold stable while tvalid & !tready; tvalid never drops mid-packet.
  - After the tlast handshake, tvalid=0 on the next cycle, the timeout counter clears, and state goes to WAIT_RESP.
- LFSR:
  - Fibonacci, shift left; new bit0 = d7^d5^d4^d3 (x^8+x^6+x^5+x^4+1).
  - Free-running across packets, advancing on handshake only.
- WAIT_RESP:
  - axis_s_tready=1.
  - Expected first beat = 8'hFF if parity==1, else 8'hAB.
  - On the first s handshake: pass++ on match, fail++ otherwise.
  - If that beat has tlast, go to GAP; otherwise go to DRAIN.
  - If RESP_TIMEOUT cycles elapse with no handshake: fail++, go to GAP, axis_s_tready drops.
- DRAIN:
  - axis_s_tready=1; beats are discarded without checking.
  - The tlast handshake moves to GAP.
  - No timeout in DRAIN.
- GAP:
  - Counts GAP_CYCLES cycles (0 → a single cycle), then goes to IDLE.
  - out_done pulses in the cycle of the GAP→IDLE transition.
- Response beats arriving in IDLE, SEND or GAP are not accepted (tready=0).
- Counters saturate at 16'hFFFF with no wrap.
- A pass and a fail never occur in the same cycle.
- Reset mid-packet aborts immediately: tvalid drops asynchronously and counters clear. Downstream must tolerate the truncated packet.

Decomposition:
- Shared package parity_pkg holds:
  - Response codes RESP_ODD=8'hFF and RESP_EVEN=8'hAB, shared with the tester.
  - FSM state enum.
  - LFSR tap mask constant.
- One natural sub-module, parity_lfsr8: seed load, advance enable, 8-bit output.

Test Plan:
- Reset, start with len=1, tready=1 → one byte 8'hA5 with tlast. Parity even, so a response of 8'hAB with tlast gives pass=1, fail=0, then out_done.
- Reset, len=2 → bytes 8'hA5, 8'h4A, tlast on the second. Parity odd, so a response of 8'hFF gives pass=1; a response of 8'hAB instead gives fail=1.
- Backpressure: len=4, tready toggling every cycle → tdata/tlast held across stalls, exactly 4 handshakes, no duplicate or skipped LFSR value.
- Timeout: len=1, never drive axis_s_tvalid → fail=1 after 64 WAIT_RESP cycles, then GAP and out_done.
- Multi-beat response: 8'hAB (tlast=0), 8'h11, 8'h22 (tlast=1) → pass=1, all three beats accepted, return to IDLE.
- in_start held high through a packet → only one packet generated; len=0 sends one byte; in_reset_n asserted mid-SEND → tvalid=0 and counters 0 immediately.
